// File: rtl/dcache_pkg.sv
// Shared defaults, derived field widths and FSM state codes for the data cache.
package dcache_pkg;
    localparam int LINES_DEF = 16;
    localparam int WORDS_DEF = 4;
    localparam int OFF_W     = $clog2(WORDS_DEF);
    localparam int IDX_W     = $clog2(LINES_DEF);
    localparam int TAG_W     = 32 - 2 - OFF_W - IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache; the cache is the slave.
interface dcache_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational read port, synchronous write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(LINES)-1:0]          rd_idx,
    input  logic [$clog2(WORDS)-1:0]          rd_word,
    output logic [30-$clog2(WORDS)-$clog2(LINES)-1:0] rd_tag,
    output logic                              rd_valid,
    output logic [31:0]                       rd_data,
    input  logic                              wr_en,
    input  logic [$clog2(LINES)-1:0]          wr_idx,
    input  logic [$clog2(WORDS)-1:0]          wr_word,
    input  logic [31:0]                       wr_data,
    input  logic                              fill_en,
    input  logic [30-$clog2(WORDS)-$clog2(LINES)-1:0] fill_tag
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[{rd_idx, rd_word}];

    always_comb begin
        valid_d = valid_q;
        if (fill_en) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tags and data carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (wr_en)   data_q[{wr_idx, wr_word}] <= wr_data;
        if (fill_en) tag_q[wr_idx] <= fill_tag;
    end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-serial refill.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic clk,
    input  logic rst,
    dcache_if.slave bus
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - OW - IW;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] cnt_q, cnt_d;
    logic [29:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [29:0]   lk_waddr;
    logic [IW-1:0] idx;
    logic [OW-1:0] word;
    logic [TW-1:0] tag, rd_tag;
    logic          rd_valid, hit;
    logic [31:0]   rd_data;
    logic          wr_en, fill_en;
    logic [OW-1:0] wr_word;
    logic [31:0]   wr_data;
    logic          unused_byte_off;

    logic          stall, req, we;
    logic [31:0]   rdata, maddr, mwdata;

    assign unused_byte_off = ^bus.cpu_addr[1:0];

    // While a store is in flight the lookup must follow the latched address.
    assign lk_waddr = (state_q == ST_WRITE) ? waddr_q : bus.cpu_addr[31:2];
    assign word     = lk_waddr[OW-1:0];
    assign idx      = lk_waddr[OW +: IW];
    assign tag      = lk_waddr[29 -: TW];
    assign hit      = rd_valid && (rd_tag == tag);

    dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_word  (word),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .fill_en  (fill_en),
        .fill_tag (tag)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        stall   = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        rdata   = '0;
        maddr   = '0;
        mwdata  = '0;
        wr_en   = 1'b0;
        fill_en = 1'b0;
        wr_word = word;
        wr_data = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_write) begin
                    stall   = 1'b1;
                    state_d = ST_WRITE;
                    waddr_d = bus.cpu_addr[31:2];
                    wdata_d = bus.cpu_wdata;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        rdata = rd_data;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_REFILL;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REFILL: begin
                stall = 1'b1;
                req   = 1'b1;
                maddr = {lk_waddr[29:OW], cnt_q, 2'b00};
                if (bus.mem_ack) begin
                    wr_en   = 1'b1;
                    wr_word = cnt_q;
                    wr_data = bus.mem_rdata;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == OW'(WORDS - 1)) begin
                        fill_en = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                req    = 1'b1;
                we     = 1'b1;
                maddr  = {waddr_q, 2'b00};
                mwdata = wdata_q;
                stall  = !bus.mem_ack;
                if (bus.mem_ack) begin
                    wr_en   = hit;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = rdata;
    assign bus.mem_req   = req;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = maddr;
    assign bus.mem_wdata = mwdata;
endmodule

// File: tb/tb_dcache.sv
// Directed and randomized bench for dcache against a line-residency + memory model.
module tb_dcache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus();
    dcache #(.LINES(16), .WORDS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory, keyed by word address; unwritten words follow a hash.
    logic [31:0] mem [int unsigned];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Which 16-byte line (addr[31:4]) each index currently holds.
    bit          rvalid [16];
    logic [27:0] rline  [16];

    function automatic bit mhit(input logic [31:0] a);
        return rvalid[a[7:4]] && rline[a[7:4]] == a[31:4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rvalid[i] = 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int lat, output int stalls);
        bit hit, is_w;
        int exp_st, w, cyc;
        logic [31:0] q[$];
        logic [31:0] ea;
        is_w = wr;
        hit  = !is_w && mhit(a);
        if (is_w) begin
            q.push_back({a[31:2], 2'b00});
            exp_st = 1 + lat;
        end else if (!hit) begin
            for (int k = 0; k < 4; k++) q.push_back({a[31:4], 4'(k * 4)});
            exp_st = 1 + 4 * (lat + 1);
        end else begin
            exp_st = 0;
        end
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        stalls = 0;
        w = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (w == lat) begin
                    bus.mem_ack = 1'b1;
                    ea = (q.size() != 0) ? q.pop_front() : 32'hFFFF_FFFF;
                    chk("mem_addr", bus.mem_addr, ea);
                    chk("mem_we", bus.mem_we, is_w);
                    if (is_w) chk("mem_wdata", bus.mem_wdata, wd);
                    else      bus.mem_rdata = mem_rd(bus.mem_addr);
                    w = 0;
                end else begin
                    w++;
                end
            end
            #1;
            if (!bus.cpu_stall) break;
            stalls++;
            cyc++;
            if (cyc >= 300) break;
        end
        if (!is_w) begin
            chk("rdata", bus.cpu_rdata, mem_rd(a));
            chk("req_on_load_done", bus.mem_req, 1'b0);
        end
        chk("stall_cycles", stalls, exp_st);
        chk("acks_missing", q.size(), 0);
        if (is_w) mem[a >> 2] = wd;
        else if (!hit) begin
            rvalid[a[7:4]] = 1'b1;
            rline[a[7:4]]  = a[31:4];
        end
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        int st, acks, guard, op, lat;
        logic [31:0] a;
        rst = 1'b1;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        model_reset();
        for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'hA0 + i;
        #12;
        chk("rst_stall", bus.cpu_stall, 1'b0);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rdata", bus.cpu_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        access(1, 0, 32'h100, 0, 0, st);
        chk("miss_lat_100", st, 5);
        access(1, 0, 32'h108, 0, 0, st);
        chk("hit_lat_108", st, 0);
        access(0, 1, 32'h104, 32'hDEADBEEF, 0, st);
        access(1, 0, 32'h104, 0, 0, st);
        chk("hit_after_store", st, 0);
        access(0, 1, 32'h2000, 32'h12345678, 1, st);
        access(1, 0, 32'h2000, 0, 0, st);
        chk("miss_after_nwa", st, 5);

        // Reset in the middle of a refill, after two words have arrived.
        bus.cpu_addr = 32'h300; bus.cpu_read = 1'b1;
        acks = 0; guard = 0;
        while (acks < 2 && guard < 50) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = mem_rd(bus.mem_addr);
                acks++;
            end
            guard++;
        end
        chk("acks_before_rst", acks, 2);
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_ack = 1'b0;
        #1;
        chk("midrst_req", bus.mem_req, 1'b0);
        chk("midrst_we", bus.mem_we, 1'b0);
        bus.cpu_read = 1'b0;
        #1;
        chk("midrst_stall", bus.cpu_stall, 1'b0);
        chk("midrst_rdata", bus.cpu_rdata, 32'h0);
        chk("midrst_addr", bus.mem_addr, 32'h0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        access(1, 0, 32'h300, 0, 0, st);
        chk("reload_300", st, 5);
        access(1, 0, 32'h104, 0, 0, st);
        chk("miss_after_rst", st, 5);

        access(1, 0, 32'h100, 0, 0, st);
        access(1, 0, 32'h1100, 0, 2, st);
        chk("conflict_refill", st, 13);
        access(1, 0, 32'h100, 0, 0, st);
        chk("evicted_miss", st, 5);

        repeat (120) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            op = $urandom_range(0, 9);
            lat = $urandom_range(0, 2);
            if (op < 6)      access(1, 0, a, 0, lat, st);
            else if (op < 9) access(0, 1, a, $urandom, lat, st);
            else             access(1, 1, a, $urandom, lat, st);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
